// File: rtl/conv_frame_scheduler_if.sv
// Handshake bundle between conv_frame_scheduler and its neighbours.
// master: the scheduler (drives the o_* signals, samples the i_* signals).
// slave : the environment (window buffer, convolution engine, pixel sink).
// Signals:
//   i_start/i_kernel_sel           frame start request and kernel select
//   o_kernel_sel                   kernel select latched for the frame
//   o_win_req/o_win_x/o_win_y      window fetch request and centre coordinate
//   i_win_ack                      window present at engine inputs
//   o_conv_enable                  engine start pulse
//   i_conv_busy/valid/rgb          engine status and result
//   o_pix_valid/data/last          output pixel stream, i_pix_ready accepts
//   o_busy/o_done/o_err            frame status
interface conv_frame_scheduler_if #(
    parameter int unsigned CW = 10
);
    logic          i_start;
    logic [1:0]    i_kernel_sel;
    logic [1:0]    o_kernel_sel;
    logic          o_win_req;
    logic [CW-1:0] o_win_x;
    logic [CW-1:0] o_win_y;
    logic          i_win_ack;
    logic          o_conv_enable;
    logic          i_conv_busy;
    logic          i_conv_valid;
    logic [23:0]   i_conv_rgb;
    logic          o_pix_valid;
    logic [23:0]   o_pix_data;
    logic          o_pix_last;
    logic          i_pix_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport master (
        input  i_start, i_kernel_sel, i_win_ack, i_conv_busy, i_conv_valid, i_conv_rgb,
               i_pix_ready,
        output o_kernel_sel, o_win_req, o_win_x, o_win_y, o_conv_enable, o_pix_valid,
               o_pix_data, o_pix_last, o_busy, o_done, o_err
    );

    modport slave (
        output i_start, i_kernel_sel, i_win_ack, i_conv_busy, i_conv_valid, i_conv_rgb,
               i_pix_ready,
        input  o_kernel_sel, o_win_req, o_win_x, o_win_y, o_conv_enable, o_pix_valid,
               o_pix_data, o_pix_last, o_busy, o_done, o_err
    );
endinterface

// File: rtl/conv_frame_scheduler.sv
// Frame-level sequencer for the shared 3x3 convolution engine. Walks an
// IMG_W x IMG_H frame in raster order; interior pixels are computed by the
// engine, border pixels are emitted as black. Every register advances only
// on cycles where i_Clk_en is high.
// Ports:
//   iClk      clock
//   iRst      synchronous active-high reset
//   i_Clk_en  clock enable shared with the engine
//   bus       conv_frame_scheduler_if.master (window, engine, pixel and status signals)
module conv_frame_scheduler #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned CW      = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          i_Clk_en,
    conv_frame_scheduler_if.master        bus
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StFetch,
        StStart,
        StWait,
        StOut,
        StDone,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [CW-1:0] win_x_q, win_x_d;
    logic [CW-1:0] win_y_q, win_y_d;
    logic [23:0]   pix_q, pix_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    ksel_q, ksel_d;
    logic          err_q, err_d;

    logic          win_req;
    logic          conv_en;
    logic          pix_valid;
    logic          done;
    logic          border;
    logic          x_end;
    logic          y_end;

    assign x_end  = (x_q == CW'(IMG_W - 1));
    assign y_end  = (y_q == CW'(IMG_H - 1));
    assign border = (x_q == '0) || x_end || (y_q == '0) || y_end;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            win_x_q <= '0;
            win_y_q <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            ksel_q  <= '0;
            err_q   <= 1'b0;
        end else if (i_Clk_en) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            ksel_q  <= ksel_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        win_x_d   = win_x_q;
        win_y_d   = win_y_q;
        pix_d     = pix_q;
        cnt_d     = cnt_q;
        ksel_d    = ksel_q;
        err_d     = err_q;
        win_req   = 1'b0;
        conv_en   = 1'b0;
        pix_valid = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    ksel_d  = bus.i_kernel_sel;
                    err_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = StSel;
                end
            end
            StSel: begin
                if (border) begin
                    pix_d   = 24'h000000;
                    state_d = StOut;
                end else begin
                    // Window coordinate is registered here so it is valid for all of
                    // FETCH and then holds until the next interior pixel.
                    win_x_d = x_q;
                    win_y_d = y_q;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                win_req = 1'b1;
                if (bus.i_win_ack && !bus.i_conv_busy) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                conv_en = 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.i_conv_valid) begin
                    pix_d   = bus.i_conv_rgb;
                    state_d = StOut;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    // Set on entry so o_err is already high alongside o_done in ERR.
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                pix_valid = 1'b1;
                if (bus.i_pix_ready) begin
                    if (x_end && y_end) begin
                        state_d = StDone;
                    end else begin
                        if (x_end) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        state_d = StSel;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.o_kernel_sel  = ksel_q;
    assign bus.o_win_req     = win_req;
    assign bus.o_win_x       = win_x_q;
    assign bus.o_win_y       = win_y_q;
    assign bus.o_conv_enable = conv_en;
    assign bus.o_pix_valid   = pix_valid;
    assign bus.o_pix_data    = pix_q;
    assign bus.o_pix_last    = pix_valid && x_end && y_end;
    assign bus.o_busy        = (state_q != StIdle);
    assign bus.o_done        = done;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Self-checking bench for conv_frame_scheduler on a 4x3 frame: reset values,
// full frame, backpressure, alternating clock enable, engine timeout, and
// kernel latch / ignored restart / mid-frame reset.
module tb_conv_frame_scheduler;
    localparam int unsigned IMG_W   = 4;
    localparam int unsigned IMG_H   = 3;
    localparam int unsigned CW      = 10;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        int unsigned x;
        int unsigned y;
        logic [23:0] data;
        logic        last;
    } pix_vec_t;

    pix_vec_t exp_tab [12];

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic clk_en   = 1'b1;
    bit   alt_mode = 1'b0;
    bit   eng_on   = 1'b1;
    bit   hold_chk = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    conv_frame_scheduler_if #(.CW(CW)) bus ();

    conv_frame_scheduler #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CW     (CW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk    (clk),
        .iRst    (rst),
        .i_Clk_en(clk_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Clock enable: steady high, or toggling every cycle in alternating mode.
    always @(posedge clk) begin
        #1;
        if (alt_mode) clk_en = ~clk_en;
        else          clk_en = 1'b1;
    end

    // Engine model: result valid in the 5th enabled cycle after the START cycle.
    int eng_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            eng_cnt          <= 0;
            bus.i_conv_valid <= 1'b0;
        end else if (clk_en) begin
            bus.i_conv_valid <= 1'b0;
            if (bus.o_conv_enable && eng_on) begin
                eng_cnt        <= 1;
                bus.i_conv_rgb <= {bus.o_win_x[7:0], bus.o_win_y[7:0], 8'hA5};
            end else if (eng_cnt == 4) begin
                eng_cnt          <= 0;
                bus.i_conv_valid <= 1'b1;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Monitor, sampling on the falling edge.
    int          clr_req = 0;
    int          clr_ack = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          conv_cyc = 0;
    int          n_conv = 0;
    int          n_done = 0;
    int          hold_cmp = 0;
    int          hold_viol = 0;
    logic [23:0] cap_data [$];
    logic        cap_last [$];
    logic [48:0] snap;
    logic [48:0] prev_snap = '0;
    logic        prev_en = 1'b1;

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            clr_ack   = clr_req;
            cyc       = 0;
            start_cyc = 0;
            done_cyc  = 0;
            conv_cyc  = 0;
            n_conv    = 0;
            n_done    = 0;
            hold_cmp  = 0;
            hold_viol = 0;
            cap_data.delete();
            cap_last.delete();
        end
        snap = {bus.o_busy, bus.o_done, bus.o_err, bus.o_pix_valid, bus.o_pix_last,
                bus.o_pix_data, bus.o_win_req, bus.o_conv_enable, bus.o_kernel_sel,
                bus.o_win_x[7:0], bus.o_win_y[7:0]};
        // The edge since the previous sample was disabled: nothing may have moved.
        if (hold_chk && prev_en == 1'b0) begin
            hold_cmp++;
            if (snap !== prev_snap) hold_viol++;
        end
        prev_snap = snap;
        prev_en   = clk_en;
        if (!rst && clk_en) begin
            if (!bus.o_busy && bus.i_start) start_cyc = cyc;
            if (bus.o_conv_enable) begin
                n_conv++;
                conv_cyc = cyc;
            end
            if (bus.o_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.o_pix_valid && bus.i_pix_ready) begin
                cap_data.push_back(bus.o_pix_data);
                cap_last.push_back(bus.o_pix_last);
            end
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    // Hold i_start until it has been seen on an enabled edge.
    task automatic pulse_start(input logic [1:0] k);
        bus.i_start      = 1'b1;
        bus.i_kernel_sel = k;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clk_en) break;
        end
        @(posedge clk);
        #2;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == 0 && k < 400) begin
            step();
            k++;
        end
        if (n_done == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no o_done within %0d cycles", name, k);
        end
    endtask

    task automatic wait_cap(input int n, input string name);
        int k = 0;
        while (cap_data.size() < n && k < 400) begin
            step();
            k++;
        end
        if (cap_data.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d pixels after %0d cycles, want %0d", name, cap_data.size(), k, n);
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, cap_data.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < cap_data.size()) begin
                check($sformatf("%s_data%0d(%0d,%0d)", tag, i, exp_tab[i].x, exp_tab[i].y),
                      cap_data[i], exp_tab[i].data);
                check($sformatf("%s_last%0d", tag, i), cap_last[i], exp_tab[i].last);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0]  = '{0, 0, 24'h000000, 1'b0};
        exp_tab[1]  = '{1, 0, 24'h000000, 1'b0};
        exp_tab[2]  = '{2, 0, 24'h000000, 1'b0};
        exp_tab[3]  = '{3, 0, 24'h000000, 1'b0};
        exp_tab[4]  = '{0, 1, 24'h000000, 1'b0};
        exp_tab[5]  = '{1, 1, 24'h0101A5, 1'b0};
        exp_tab[6]  = '{2, 1, 24'h0201A5, 1'b0};
        exp_tab[7]  = '{3, 1, 24'h000000, 1'b0};
        exp_tab[8]  = '{0, 2, 24'h000000, 1'b0};
        exp_tab[9]  = '{1, 2, 24'h000000, 1'b0};
        exp_tab[10] = '{2, 2, 24'h000000, 1'b0};
        exp_tab[11] = '{3, 2, 24'h000000, 1'b1};

        bus.i_start      = 1'b0;
        bus.i_kernel_sel = 2'd0;
        bus.i_win_ack    = 1'b1;
        bus.i_conv_busy  = 1'b0;
        bus.i_pix_ready  = 1'b1;

        // ---- Reset with random inputs ----
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.i_start      = 1'($urandom_range(0, 1));
            bus.i_kernel_sel = 2'($urandom_range(0, 3));
            bus.i_win_ack    = 1'($urandom_range(0, 1));
            bus.i_conv_busy  = 1'($urandom_range(0, 1));
            bus.i_pix_ready  = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_kernel_sel", bus.o_kernel_sel, 0);
        check("rst_win_req", bus.o_win_req, 0);
        check("rst_win_x", bus.o_win_x, 0);
        check("rst_win_y", bus.o_win_y, 0);
        check("rst_conv_enable", bus.o_conv_enable, 0);
        check("rst_pix_valid", bus.o_pix_valid, 0);
        check("rst_pix_data", bus.o_pix_data, 0);
        check("rst_pix_last", bus.o_pix_last, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        bus.i_start     = 1'b0;
        bus.i_win_ack   = 1'b1;
        bus.i_conv_busy = 1'b0;
        bus.i_pix_ready = 1'b1;
        rst = 1'b0;
        step();

        // ---- Full frame ----
        clear_stats();
        pulse_start(2'd1);
        check("start_busy", bus.o_busy, 1);
        wait_done("full_done");
        check("full_busy_after", bus.o_busy, 0);
        check("full_kernel", bus.o_kernel_sel, 1);
        check_frame("full");
        check("full_done_latency", done_cyc - start_cyc, 39);
        check("full_conv_pulses", n_conv, 2);
        check("full_done_pulses", n_done, 1);
        check("full_err", bus.o_err, 0);
        step();

        // ---- Backpressure on pixel (1,1) ----
        clear_stats();
        pulse_start(2'd0);
        begin
            int k = 0;
            while (!(bus.o_win_req && bus.o_win_x == 1 && bus.o_win_y == 1) && k < 100) begin
                step();
                k++;
            end
            bus.i_pix_ready = 1'b0;
            k = 0;
            while (!bus.o_pix_valid && k < 100) begin
                step();
                k++;
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_valid%0d", i), bus.o_pix_valid, 1);
                check($sformatf("bp_data%0d", i), bus.o_pix_data, 24'h0101A5);
                check($sformatf("bp_last%0d", i), bus.o_pix_last, 0);
                check($sformatf("bp_win%0d", i), {bus.o_win_x, bus.o_win_y}, {10'd1, 10'd1});
                if (i < 2) step();
            end
            check("bp_no_transfer", cap_data.size(), 5);
            bus.i_pix_ready = 1'b1;
        end
        wait_done("bp_done");
        check_frame("bp");
        step();

        // ---- Alternating clock enable ----
        clear_stats();
        alt_mode = 1'b1;
        hold_chk = 1'b1;
        pulse_start(2'd3);
        wait_done("ce_done");
        hold_chk = 1'b0;
        check_frame("ce");
        check("ce_done_latency", done_cyc - start_cyc, 39);
        check("ce_conv_pulses", n_conv, 2);
        check("ce_hold_samples", hold_cmp > 30, 1);
        check("ce_hold_violations", hold_viol, 0);
        alt_mode = 1'b0;
        step();
        step();

        // ---- Engine timeout ----
        clear_stats();
        eng_on = 1'b0;
        pulse_start(2'd0);
        wait_done("to_done");
        step();
        check("to_err", bus.o_err, 1);
        check("to_busy_after", bus.o_busy, 0);
        check("to_pix_count", cap_data.size(), 5);
        for (int i = 0; i < cap_data.size(); i++) begin
            check($sformatf("to_black%0d", i), cap_data[i], 24'h000000);
        end
        check("to_start_to_done", done_cyc - conv_cyc, 17);
        check("to_conv_pulses", n_conv, 1);
        check("to_done_pulses", n_done, 1);
        eng_on = 1'b1;
        pulse_start(2'd0);
        check("to_err_cleared", bus.o_err, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // ---- Kernel latch, ignored restart, mid-frame reset ----
        clear_stats();
        pulse_start(2'd2);
        bus.i_kernel_sel = 2'd3;
        wait_cap(3, "ka_cap3");
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("ka_kernel_held", bus.o_kernel_sel, 2);
        check("ka_busy", bus.o_busy, 1);
        wait_cap(6, "ka_cap6");
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("ka_pix_count", cap_data.size(), 6);
        if (cap_data.size() >= 6) check("ka_pix5", cap_data[5], 24'h0101A5);
        check("ka_conv_pulses", n_conv, 1);
        check("ka_no_done", n_done, 0);
        check("ka_busy_after", bus.o_busy, 0);
        check("ka_kernel_rst", bus.o_kernel_sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
